// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between NUM_REQ requesters,
// with bounded burst lock. Define RAM_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.

module ram_arbiter_lane #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  gnt,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wr,
  output logic                  rd,
  output logic [ADDR_WIDTH-1:0] addr_m,
  output logic [DATA_WIDTH-1:0] data_m
);
  // Masked contribution so the top can OR all lanes into the RAM command.
  assign wr     = gnt & we;
  assign rd     = gnt & ~we;
  assign addr_m = gnt ? addr  : '0;
  assign data_m = gnt ? wdata : '0;
endmodule

module ram_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int LOCK_MAX   = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ-1:0]              req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            lock_break,
  output logic                            ram_wr_en,
  output logic                            ram_rd_en,
  output logic [ADDR_WIDTH-1:0]           ram_addr,
  output logic [DATA_WIDTH-1:0]           ram_din,
  input  logic [DATA_WIDTH-1:0]           ram_dout
);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t        state;
  logic [PW-1:0] owner;
  logic [7:0]    lock_cnt;
  logic [PW-1:0] start;
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic [PW-1:0] ptr;
  assign start = ptr;
`else
  assign start = '0;
`endif

  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      gidx;
  logic [PW:0]        idx;
  logic               found;

  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    if (state == LOCKED) begin
      grant[owner] = req_valid[owner];
      gidx         = owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = {1'b0, start} + (PW+1)'(k);
        if (idx >= (PW+1)'(NUM_REQ)) idx = idx - (PW+1)'(NUM_REQ);
        if (!found && req_valid[idx[PW-1:0]]) begin
          found                 = 1'b1;
          gidx                  = idx[PW-1:0];
          grant[idx[PW-1:0]]    = 1'b1;
        end
      end
    end
  end

  logic accept, gwe, glock;
  assign accept    = |grant;
  assign gwe       = req_we[gidx];
  assign glock     = req_lock[gidx];
  assign req_ready = grant;
  assign rsp_rdata = ram_dout;

  logic [NUM_REQ-1:0]                 lane_wr, lane_rd;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] lane_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_data;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    ram_arbiter_lane #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lane (
      .gnt    (grant[i]),
      .we     (req_we[i]),
      .addr   (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .wdata  (req_wdata[i*DATA_WIDTH +: DATA_WIDTH]),
      .wr     (lane_wr[i]),
      .rd     (lane_rd[i]),
      .addr_m (lane_addr[i]),
      .data_m (lane_data[i])
    );
  end

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ram_addr = ram_addr | lane_addr[i];
      ram_din  = ram_din  | lane_data[i];
    end
  end
  assign ram_wr_en = |lane_wr;
  assign ram_rd_en = |lane_rd;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ARB;
      owner      <= '0;
      lock_cnt   <= '0;
      rsp_valid  <= '0;
      lock_break <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      ptr        <= '0;
`endif
    end else begin
      rsp_valid  <= (accept && !gwe) ? grant : '0;
      lock_break <= 1'b0;
      if (accept) begin
`ifndef RAM_ARB_FIXED_PRIO_EN
        ptr <= (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + PW'(1);
`endif
        case (state)
          ARB: begin
            if (glock && LOCK_MAX > 1) begin
              state    <= LOCKED;
              owner    <= gidx;
              lock_cnt <= 8'd1;
            end
          end
          LOCKED: begin
            // An explicit unlock on the final allowed beat counts as a normal release.
            if (!glock) begin
              state    <= ARB;
              lock_cnt <= '0;
            end else if (lock_cnt + 8'd1 == 8'(LOCK_MAX)) begin
              state      <= ARB;
              lock_cnt   <= '0;
              lock_break <= 1'b1;
            end else begin
              lock_cnt <= lock_cnt + 8'd1;
            end
          end
          default: state <= ARB;
        endcase
      end
    end
  end
endmodule
